dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dmemory32, RAM on inverted clock) between two requesters:
//  port 0 = CPU load/store unit, port 1 = UART program/data loader. One access issued per cycle,
//  registered issue stage drives the memory, read data returned with a valid pulse. Sits between
//  the requesters and dmemory32; dmemory32 is unchanged.
// PARAMETERS
//  PRIO_MODE  0  0 = round-robin; 1 = fixed priority to port 0 (with starvation guard)
//  MAX_BURST  4  fixed mode only: max consecutive port-0 grants while req1 pending (1..15)
//  ADDR_BITS  16 byte-address bits backed by RAM (14-bit word address = addr[15:2])
// PORTS
//  clock      in   1   system clock (same clock that feeds dmemory32)
//  resetn     in   1   asynchronous active-low reset
//  req0/req1  in   1   access request; hold req, we, addr, wdata stable until gnt
//  we0/we1    in   1   1 = write, 0 = read
//  addr0/1    in   32  byte address
//  wdata0/1   in   32  write data
//  gnt0/gnt1  out  1   combinational accept, same cycle as req; at most one high
//  rvalid0/1  out  1   one-cycle pulse: read data (or error) for that port
//  rdata0/1   out  32  read data, valid while rvalid; held otherwise
//  err0/err1  out  1   pulse with completion timing: access rejected (misaligned/out of range)
//  mem_write  out  1   to dmemory32 Memwrite
//  mem_addr   out  32  to dmemory32 address
//  mem_wdata  out  32  to dmemory32 write_data
//  mem_rdata  in   32  from dmemory32 read_data
// BEHAVIOUR
//  Reset: issue_valid, mem_write, mem_addr, mem_wdata, gnt*, rvalid*, rdata*, err*, burst counter
//   and RR pointer all 0 (RR pointer 0 => port 0 favoured first). Reset asynchronously kills any
//   in-flight access: mem_write drops immediately, no rvalid/err after reset.
//  Stage A (cycle c): winner chosen among asserted reqs; gnt of winner high. At posedge end of c,
//   issue reg <= {valid=1, id, we, addr, wdata, bad}; no req => issue_valid <= 0.
//  Stage B (cycle c+1): mem_addr/mem_wdata from issue reg; mem_write = valid & we & ~bad. RAM
//   samples on falling edge of clock mid-cycle; at posedge end of c+1 result captured.
//  Stage C (cycle c+2): for read or bad access, rvalid_id=1 and rdata_id=mem_rdata (0 if bad);
//   err_id=bad. Good writes produce no rvalid (fire-and-forget, write done by end of c+1).
//  Latency accept->rvalid = 2 cycles; throughput 1 access/cycle; back-to-back from either port.
//  bad = addr[1:0]!=0 or addr[31:ADDR_BITS]!=0. Bad accesses are granted (never stall) but never
//   write RAM.
//  Round-robin: both req => grant port != last granted; RR pointer updates on every grant.
//  Fixed: port 0 wins unless req1 pending and burst counter == MAX_BURST, then port 1 wins once.
//   Counter increments on each port-0 grant while req1 high, clears on port-1 grant or req1 low;
//   saturates at MAX_BURST.
//  Single requester: granted every cycle it requests, regardless of mode or pointer.
//  Read-after-write same address in consecutive cycles returns new data (write lands at c+1
//   negedge, read samples at c+2 negedge).
//  rdata of a port holds its last value between rvalid pulses.
// TESTING
//  1 Reset: hold resetn=0 with req0=1,we0=1 -> gnt*, mem_write, rvalid*, err* all 0; release ->
//    gnt0 same cycle, mem_write=1 next cycle.
//  2 Port 0 write 0x0000_0010 <= 0xDEAD_BEEF, then read 0x10 next cycle -> rvalid0 2 cycles after
//    read gnt0, rdata0=0xDEADBEEF, err0=0.
//  3 RR mode, req0 & req1 held high 6 cycles -> grants alternate 0,1,0,1,0,1; each read returns
//    its own port's rvalid exactly 2 cycles after its gnt.
//  4 Fixed mode, MAX_BURST=4, both held -> grant pattern 0,0,0,0,1,0,0,0,0,1; req1 low -> all 0.
//  5 Port 1 write to 0x0000_0003 and to 0x0001_0000 -> mem_write stays 0, err1 pulse with
//    rdata1=0 2 cycles after each gnt1; subsequent read of 0x0 unchanged.
//  6 Assert resetn=0 the cycle after a read gnt -> no rvalid ever issues; post-reset read ok.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets two requesters share one single-port data memory.
// Each access is accepted, then issued from a register; read data returns two cycles after the grant.
module dmem_arbiter #(
   parameter int PRIO_MODE = 0,
   parameter int MAX_BURST = 4,
   parameter int ADDR_BITS = 16
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   typedef struct packed {
      logic        valid;
      logic        id;
      logic        we;
      logic        bad;
      logic [31:0] addr;
      logic [31:0] wdata;
   } issue_t;

   issue_t      iss;
   logic        rr_ptr;
   logic [3:0]  burst;
   logic        sel1;
   logic        any_gnt;
   logic        in_we;
   logic        in_bad;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;

   always_comb begin
      sel1 = 1'b0;
      unique case (1'b1)
         (req0 & req1): begin
            if (PRIO_MODE == 0) sel1 = rr_ptr;
            else                sel1 = (burst == MAXB);
         end
         (req1 & ~req0): sel1 = 1'b1;
         default:        sel1 = 1'b0;
      endcase
   end

   // reset also blocks acceptance so nothing is granted while held in reset
   assign any_gnt  = resetn & (req0 | req1);
   assign gnt0     = any_gnt & ~sel1;
   assign gnt1     = any_gnt & sel1;

   assign in_we    = sel1 ? we1    : we0;
   assign in_addr  = sel1 ? addr1  : addr0;
   assign in_wdata = sel1 ? wdata1 : wdata0;
   assign in_bad   = (in_addr[1:0] != 2'b00) ||
                     ((in_addr >> ADDR_BITS) != 32'd0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         iss     <= '0;
         rr_ptr  <= 1'b0;
         burst   <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         iss.valid <= any_gnt;
         if (any_gnt) begin
            iss.id    <= sel1;
            iss.we    <= in_we;
            iss.bad   <= in_bad;
            iss.addr  <= in_addr;
            iss.wdata <= in_wdata;
            rr_ptr    <= ~sel1;
         end

         if (!req1 || gnt1)
            burst <= '0;
         else if (gnt0 && burst != MAXB)
            burst <= burst + 4'd1;

         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         // good writes complete silently; reads and rejects report back
         if (iss.valid && (!iss.we || iss.bad)) begin
            if (iss.id) begin
               rvalid1 <= 1'b1;
               err1    <= iss.bad;
               rdata1  <= iss.bad ? 32'd0 : mem_rdata;
            end else begin
               rvalid0 <= 1'b1;
               err0    <= iss.bad;
               rdata0  <= iss.bad ? 32'd0 : mem_rdata;
            end
         end
      end
   end

   assign mem_write = iss.valid & iss.we & ~iss.bad;
   assign mem_addr  = iss.addr;
   assign mem_wdata = iss.wdata;

endmodule
